// File: rtl/ndp_axis_upsizer.sv
// AXI4-Stream width upsizer: packs RATIO narrow beats into one LANES*LANE_W word
// with a per-lane valid mask, buffered in a small output FIFO. NDP_AXIS_STATS_EN adds counters.
module ndp_axis_upsizer #(
  parameter int IN_W       = 32,
  parameter int LANE_W     = 16,
  parameter int LANES      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [IN_W-1:0]               s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [LANES*LANE_W-1:0]       m_axis_tdata,
  output logic [LANES-1:0]              m_axis_tlane,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef NDP_AXIS_STATS_EN
  ,
  output logic [31:0]                   stat_beats,
  output logic [31:0]                   stat_words,
  output logic [31:0]                   stat_pkts
`endif
);

  localparam int OUT_W = LANES * LANE_W;
  localparam int RATIO = OUT_W / IN_W;
  localparam int LPB   = IN_W / LANE_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [LANES-1:0] lane;
    logic             last;
  } entry_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] asm_q, asm_d;
  logic             tready_q;
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [LVL_W-1:0] count_q, count_d;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           hold_q;
  entry_t           head;
  entry_t           push_entry;
  logic             accept, push, pop;

  assign accept = s_axis_tvalid && tready_q;
  assign pop    = (count_q != '0) && m_axis_tready;

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      // Bits above the current beat are already zero because the assembler is cleared on push.
      push_entry.data = asm_q;
      push_entry.data[int'(cnt_q)*IN_W +: IN_W] = s_axis_tdata;
      for (int i = 0; i < LANES; i++) begin
        push_entry.lane[i] = (i < (int'(cnt_q) + 1) * LPB);
      end
      push_entry.last = s_axis_tlast;
      if ((int'(cnt_q) == RATIO - 1) || s_axis_tlast) begin
        push  = 1'b1;
        cnt_d = '0;
        asm_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        asm_d = push_entry.data;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      cnt_q    <= '0;
      asm_q    <= '0;
      tready_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      tready_q <= (int'(count_d) < FIFO_DEPTH);
      count_q  <= count_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        hold_q <= head;
      end
    end
  end

  // NOTE: storage is not reset; count gates visibility and hold_q supplies the idle/reset value.
  always_ff @(posedge axi_aclk) begin
    if (push) mem_q[wr_q] <= push_entry;
  end

  // While empty the last popped word stays on the bus.
  assign head = (count_q != '0) ? mem_q[rd_q] : hold_q;

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = head.data;
  assign m_axis_tlane  = head.lane;
  assign m_axis_tlast  = head.last;
  assign fifo_level    = count_q;

`ifdef NDP_AXIS_STATS_EN
  logic [31:0] beats_q, words_q, pkts_q;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      beats_q <= '0;
      words_q <= '0;
      pkts_q  <= '0;
    end else begin
      if (accept) beats_q <= beats_q + 32'd1;
      if (pop) words_q <= words_q + 32'd1;
      if (pop && head.last) pkts_q <= pkts_q + 32'd1;
    end
  end

  assign stat_beats = beats_q;
  assign stat_words = words_q;
  assign stat_pkts  = pkts_q;
`endif

endmodule

// File: tb/tb_ndp_axis_upsizer.sv
// Directed bench for ndp_axis_upsizer at default parameters; define NDP_AXIS_STATS_EN
// to also exercise the statistics counters.
module tb_ndp_axis_upsizer;

  logic         clk;
  logic         rstn;
  logic [31:0]  s_tdata;
  logic         s_tlast;
  logic         s_tvalid;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic [15:0]  m_tlane;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [2:0]   level;
`ifdef NDP_AXIS_STATS_EN
  logic [31:0]  stat_beats, stat_words, stat_pkts;
`endif

  typedef struct {
    logic [255:0] data;
    logic [15:0]  lane;
    logic         last;
  } word_t;

  word_t got_q[$];
  int    total = 0;
  int    bad   = 0;
  int    max_level = 0;

  ndp_axis_upsizer dut (
    .axi_aclk      (clk),
    .axi_aresetn   (rstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlane  (m_tlane),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .fifo_level    (level)
`ifdef NDP_AXIS_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_words    (stat_words),
    .stat_pkts     (stat_pkts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: a word is popped at the next rising edge when valid and ready hold here.
  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) begin
      got_q.push_back('{data: m_tdata, lane: m_tlane, last: m_tlast});
    end
    if (rstn && int'(level) > max_level) max_level = int'(level);
  end

  function automatic logic [255:0] exp_word(input logic [31:0] base);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = base + k;
    return w;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [31:0] d, input logic l);
    bit done;
    done = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_beat timeout: beat %h not accepted within 64 cycles", d);
    end
  endtask

  task automatic send_group(input logic [31:0] base, input int n, input logic last_on_end);
    for (int k = 0; k < n; k++) send_beat(base + k, last_on_end && (k == n - 1));
  endtask

  task automatic check_word(input string name, input word_t w, input logic [255:0] d,
                            input logic [15:0] ln, input logic lst);
    total++;
    if (w.data !== d || w.lane !== ln || w.last !== lst) begin
      bad++;
      $display("FAIL %s: got data=%h lane=%h last=%b want data=%h lane=%h last=%b",
               name, w.data, w.lane, w.last, d, ln, lst);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wait_cycles(3);
    total++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 ||
        m_tdata !== '0 || m_tlane !== '0 || level !== '0) begin
      bad++;
      $display("FAIL reset_state: tready=%b tvalid=%b tlast=%b tdata=%h tlane=%h level=%0d want all 0",
               s_tready, m_tvalid, m_tlast, m_tdata, m_tlane, level);
    end
    rstn = 1'b1;
    wait_cycles(1);
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_tready: got %b want 1", s_tready);
    end
  endtask

  task automatic test_full_word();
    got_q.delete();
    m_tready = 1'b1;
    send_group(32'h1, 8, 1'b1);
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001 ||
        m_tlane !== 16'hFFFF || m_tlast !== 1'b1) begin
      bad++;
      $display("FAIL full_word: tvalid=%b data=%h lane=%h last=%b want 1 / 8..1 / ffff / 1",
               m_tvalid, m_tdata, m_tlane, m_tlast);
    end
    wait_cycles(3);
    total++;
    if (got_q.size() != 1 || m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL full_word_count: got %0d words tvalid=%b want 1 word tvalid=0", got_q.size(), m_tvalid);
    end
  endtask

  task automatic test_partial();
    got_q.delete();
    send_beat(32'hAAAA0001, 1'b0);
    send_beat(32'hAAAA0002, 1'b0);
    send_beat(32'hAAAA0003, 1'b1);
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 256'hAAAA0003_AAAA0002_AAAA0001 ||
        m_tlane !== 16'h003F || m_tlast !== 1'b1) begin
      bad++;
      $display("FAIL partial_word: tvalid=%b data=%h lane=%h last=%b want 1 / aaaa0003_aaaa0002_aaaa0001 / 003f / 1",
               m_tvalid, m_tdata, m_tlane, m_tlast);
    end
    wait_cycles(3);
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL partial_count: got %0d words want 1", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    m_tready = 1'b0;
    for (int w = 0; w < 4; w++) send_group(32'h100 + 8 * w, 8, 1'b0);
    total++;
    if (level !== 3'd4 || s_tready !== 1'b0) begin
      bad++;
      $display("FAIL bp_full: level=%0d tready=%b want 4 / 0", level, s_tready);
    end
    s_tdata  = 32'h120;
    s_tvalid = 1'b1;
    wait_cycles(5);
    total++;
    if (level !== 3'd4 || s_tready !== 1'b0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL bp_hold: level=%0d tready=%b words=%0d want 4 / 0 / 0", level, s_tready, got_q.size());
    end
    m_tready = 1'b1;
    send_group(32'h120, 8, 1'b1);
    wait_cycles(10);
    total++;
    if (got_q.size() != 5) begin
      bad++;
      $display("FAIL bp_count: got %0d words want 5", got_q.size());
    end else begin
      for (int w = 0; w < 5; w++) begin
        check_word($sformatf("bp_word%0d", w), got_q[w], exp_word(32'h100 + 8 * w), 16'hFFFF, w == 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    max_level = 0;
    m_tready = 1'b1;
    for (int w = 0; w < 8; w++) send_group(32'h1000 + 8 * w, 8, w == 7);
    wait_cycles(4);
    total++;
    if (got_q.size() != 8 || max_level > 1) begin
      bad++;
      $display("FAIL b2b_rate: words=%0d max_level=%0d want 8 / <=1", got_q.size(), max_level);
    end else begin
      check_word("b2b_first", got_q[0], exp_word(32'h1000), 16'hFFFF, 1'b0);
      check_word("b2b_last", got_q[7], exp_word(32'h1038), 16'hFFFF, 1'b1);
    end
  endtask

  task automatic test_push_pop_same_edge();
    got_q.delete();
    m_tready = 1'b0;
    send_group(32'h300, 8, 1'b0);
    send_group(32'h400, 7, 1'b0);
    total++;
    if (level !== 3'd1) begin
      bad++;
      $display("FAIL pp_pre_level: got %0d want 1", level);
    end
    m_tready = 1'b1;
    send_beat(32'h407, 1'b1);
    total++;
    if (level !== 3'd1 || m_tdata !== exp_word(32'h400) || m_tlast !== 1'b1) begin
      bad++;
      $display("FAIL pp_same_edge: level=%0d data=%h last=%b want 1 / %h / 1",
               level, m_tdata, m_tlast, exp_word(32'h400));
    end
    wait_cycles(3);
    total++;
    if (got_q.size() != 2 || level !== '0) begin
      bad++;
      $display("FAIL pp_drain: words=%0d level=%0d want 2 / 0", got_q.size(), level);
    end else begin
      check_word("pp_word0", got_q[0], exp_word(32'h300), 16'hFFFF, 1'b0);
    end
  endtask

  task automatic test_reset_mid_packet();
    got_q.delete();
    m_tready = 1'b1;
    send_group(32'hDEAD0000, 5, 1'b0);
    rstn = 1'b0;
    wait_cycles(1);
    total++;
    if (level !== '0 || m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_level: level=%0d tvalid=%b want 0 / 0", level, m_tvalid);
    end
    rstn = 1'b1;
    wait_cycles(1);
    send_group(32'h200, 8, 1'b1);
    wait_cycles(3);
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL mid_reset_count: got %0d words want 1", got_q.size());
    end else begin
      check_word("mid_reset_word", got_q[0], exp_word(32'h200), 16'hFFFF, 1'b1);
    end
  endtask

`ifdef NDP_AXIS_STATS_EN
  task automatic test_stats();
    rstn = 1'b0;
    wait_cycles(2);
    rstn = 1'b1;
    wait_cycles(1);
    m_tready = 1'b1;
    send_group(32'h500, 8, 1'b1);
    send_group(32'h600, 3, 1'b1);
    wait_cycles(4);
    total++;
    if (stat_beats !== 32'd11 || stat_words !== 32'd2 || stat_pkts !== 32'd2) begin
      bad++;
      $display("FAIL stats: beats=%0d words=%0d pkts=%0d want 11 / 2 / 2", stat_beats, stat_words, stat_pkts);
    end
  endtask
`endif

  initial begin
    rstn     = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    wait_cycles(1);
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_push_pop_same_edge();
    test_reset_mid_packet();
`ifdef NDP_AXIS_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
